// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, flag bit positions and default width for the 6-bit ALU.
// Opcodes 110/111 are shifts only when ALU_EXT_OPS_EN is defined.
package alu_pkg;
    localparam int DEF_WIDTH = 6;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 0;
endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational ALU datapath producing next result and flags.
// Shifter exists only when ALU_EXT_OPS_EN is defined; otherwise 110/111 yield zero.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2:0]       s,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [1:0]       flags
);
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    assign w_sum = {1'b0, a} + {1'b0, b};
    // The extra top bit of the difference is the borrow when a < b.
    assign w_dif = {1'b0, a} - {1'b0, b};
`ifdef ALU_EXT_OPS_EN
    logic [WIDTH:0] w_shl;
    logic [WIDTH:0] w_shr;
    // The guard bit beside the operand catches the last bit shifted out.
    assign w_shl = {1'b0, a} << b[2:0];
    assign w_shr = {a, 1'b0} >> b[2:0];
`endif
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        case (s)
            OP_ADD: {w_c, w_res} = w_sum;
            OP_SUB: {w_c, w_res} = w_dif;
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_NOT: w_res = ~a;
            OP_XOR: w_res = a ^ b;
`ifdef ALU_EXT_OPS_EN
            OP_SLL: {w_c, w_res} = w_shl;
            OP_SRL: {w_res, w_c} = w_shr;
`endif
            default: ;
        endcase
    end
    assign y             = w_res;
    assign flags[FLAG_C] = w_c;
    assign flags[FLAG_Z] = (w_res == '0);
endmodule

// File: rtl/alu_6bit.sv
// alu_6bit: registered ALU top; one-cycle latency, async active-low reset.
// Define ALU_EXT_OPS_EN to enable shift opcodes 110/111.
module alu_6bit
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       s,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [1:0]       f,
    output logic [WIDTH-1:0] result
);
    logic [WIDTH-1:0] w_res;
    logic [1:0]       w_flags;
    logic [WIDTH-1:0] r_result;
    logic [1:0]       r_f;
    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .s     (s),
        .a     (a),
        .b     (b),
        .y     (w_res),
        .flags (w_flags)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_f      <= '0;
        end else begin
            r_result <= w_res;
            r_f      <= w_flags;
        end
    end
    assign result = r_result;
    assign f      = r_f;
endmodule

// File: tb/tb_alu_6bit.sv
// tb_alu_6bit: scoreboard bench for alu_6bit; expectations come from an integer model.
module tb_alu_6bit;
    localparam int W = 6;
    localparam int M = 1 << W;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   s = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   f;
    logic [W-1:0] result;
    logic [W+1:0] sb_q[$];
    int           n_checks = 0;
    int           n_fail = 0;
    alu_6bit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s      (s),
        .a      (a),
        .b      (b),
        .f      (f),
        .result (result)
    );
    always #5 clk = ~clk;
    function automatic logic [W+1:0] model(input int op, input int x, input int y);
        int r;
        int n;
        int c;
        r = 0;
        c = 0;
        n = y & 7;
        case (op)
            0: begin r = x + y; c = (r >= M) ? 1 : 0; r = r % M; end
            1: begin c = (x < y) ? 1 : 0; r = (x - y + M) % M; end
            2: r = x & y;
            3: r = x | y;
            4: r = (~x) & (M - 1);
            5: r = x ^ y;
`ifdef ALU_EXT_OPS_EN
            6: begin r = (x << n) % M; c = (n == 0) ? 0 : ((x << (n - 1)) >> (W - 1)) & 1; end
            7: begin r = x >> n; c = (n == 0) ? 0 : (x >> (n - 1)) & 1; end
`endif
            default: r = 0;
        endcase
        model = {r[W-1:0], c[0], (r == 0)};
    endfunction
    task automatic check(input string tag, input logic [W+1:0] got, input logic [W+1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got result=%0d f=%b, expected result=%0d f=%b",
                     tag, got[W+1:2], got[1:0], exp[W+1:2], exp[1:0]);
        end
    endtask
    task automatic step(input string tag, input int op, input int x, input int y);
        @(negedge clk);
        s = op[2:0];
        a = x[W-1:0];
        b = y[W-1:0];
        sb_q.push_back(model(op, x, y));
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) check({tag, "_sb_empty"}, {result, f}, 'x);
        else check(tag, {result, f}, sb_q.pop_front());
    endtask
    initial begin
        int sa;
        int sbv;
        a = 6'd5;
        b = 6'd3;
        s = 3'b000;
        #2;
        check("reset_async", {result, f}, {6'd0, 2'b00});
        @(negedge clk);
        rst_n = 1'b1;
        step("add_3_5", 0, 3, 5);
        check("add_3_5_const", {result, f}, {6'd8, 2'b00});
        step("add_62_2", 0, 62, 2);
        check("add_62_2_const", {result, f}, {6'd0, 2'b11});
        step("sub_5_5", 1, 5, 5);
        check("sub_5_5_const", {result, f}, {6'd0, 2'b01});
        step("sub_0_1", 1, 0, 1);
        check("sub_0_1_const", {result, f}, {6'd63, 2'b10});
        step("and", 2, 42, 15);
        check("and_const", {result, f}, {6'd10, 2'b00});
        step("or", 3, 42, 15);
        check("or_const", {result, f}, {6'd47, 2'b00});
        step("xor", 5, 42, 15);
        check("xor_const", {result, f}, {6'd37, 2'b00});
        step("not", 4, 42, 15);
        check("not_const", {result, f}, {6'd21, 2'b00});
        step("op7", 7, 40, 3);
`ifdef ALU_EXT_OPS_EN
        check("op7_const", {result, f}, {6'd5, 2'b00});
        step("sll_by0", 6, 33, 0);
        step("sll_by1", 6, 33, 1);
        step("sll_by6", 6, 1, 6);
        step("srl_by7", 7, 63, 7);
`else
        check("op7_const", {result, f}, {6'd0, 2'b01});
        step("op6", 6, 63, 63);
        check("op6_const", {result, f}, {6'd0, 2'b01});
`endif
        step("not_63", 4, 63, 0);
        check("not_63_const", {result, f}, {6'd0, 2'b01});
        // Mid-cycle reset must clear outputs at once and hold them through an edge.
        step("pre_reset", 0, 20, 20);
        @(negedge clk);
        a = 6'd5;
        b = 6'd3;
        s = 3'b000;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid", {result, f}, {6'd0, 2'b00});
        @(posedge clk);
        #1;
        check("reset_hold", {result, f}, {6'd0, 2'b00});
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset", 0, 5, 3);
        check("post_reset_const", {result, f}, {6'd8, 2'b00});
        sa = 1;
        sbv = 60;
        for (int i = 0; i < 36; i++) begin
            step("sweep", i % 6, sa % M, (sbv + M) % M);
            sa += 2;
            sbv -= 1;
        end
        for (int i = 0; i < 40; i++)
            step("random", $urandom_range(7, 0), $urandom_range(M - 1, 0), $urandom_range(M - 1, 0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
